matmul_job_scheduler: RTL and testbench
=======================================

# matmul_job_scheduler

- Shares one `matrix_multiplier` instance among `NUM_REQ` requesters, such as the Q/K/V projection and attention-score engines.
- Arbitration is round-robin. Each winner's job descriptor (dimensions plus base addresses) is captured and driven onto the multiplier control port.
- The block sequences `start`/`done`, runs a watchdog on each job and returns a per-requester completion or error pulse.
- It sits between the transformer layer controllers and the multiplier, and owns the base-address offsets that are added to the multiplier's `addr_a/b/c`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DIM_WIDTH`, 16: width of the matrix dimension fields.
- `ADDR_WIDTH`, 10: width of the base-address fields.
- `TIMEOUT_CYCLES`, 65535: watchdog limit, in cycles, spent in WAIT.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- `req_rows_a`, `req_cols_a`, `req_cols_b`  in  NUM_REQ*DIM_WIDTH each  packed descriptors; requester i occupies slice [i*DIM_WIDTH +: DIM_WIDTH].
- `req_base_a`, `req_base_b`, `req_base_c`  in  NUM_REQ*ADDR_WIDTH each  packed base addresses.
- `rsp_done`  out  NUM_REQ  one-cycle completion pulse.
- `rsp_error`  out  NUM_REQ  one-cycle pulse for a rejected or timed-out job.
- `mm_start`  out  1  one-cycle start pulse to the multiplier.
- `mm_rows_a`, `mm_cols_a`, `mm_cols_b`  out  DIM_WIDTH  latched dimensions.
- `mm_base_a`, `mm_base_b`, `mm_base_c`  out  ADDR_WIDTH  latched base offsets.
- `mm_ready`  in  1  multiplier idle.
- `mm_done`  in  1  multiplier completion pulse.
- `busy`  out  1  high whenever state is not IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `job_count`  out  16  count of completed jobs; wraps to 0.
- `error_count`  out  8  count of errored jobs; saturates at 255.

## Operation
- States are IDLE, LAUNCH, REJECT and WAIT.
- **IDLE:**
  - If any `req_valid` is high and `mm_ready`=1, pick winner g by round-robin. The search starts at `last_grant+1` modulo NUM_REQ.
  - Latch g's descriptor and set `grant_id`=g.
  - If any of g's dimensions is 0, go to REJECT; otherwise go to LAUNCH.
  - If `mm_ready`=0, stay in IDLE and grant nobody.
- **LAUNCH** (1 cycle): `req_ready[g]`=1 and `mm_start`=1 in the same cycle; clear the watchdog; go to WAIT.
- **REJECT** (1 cycle):
  - `req_ready[g]`=1 and `rsp_error[g]`=1; `mm_start` stays 0.
  - `error_count`++; set `last_grant`=g; go to IDLE.
- **WAIT:**
  - Watchdog increments every cycle.
  - On `mm_done`=1: next cycle `rsp_done[g]`=1, `job_count`++, `last_grant`=g, go to IDLE.
  - When the watchdog reaches TIMEOUT_CYCLES-1 without `mm_done`: next cycle `rsp_error[g]`=1, `error_count`++, `last_grant`=g, go to IDLE.
  - `mm_done` and timeout in the same cycle: done wins.
- Requester handshake:
  - Hold `req_valid` and the descriptor stable until `req_ready` is seen.
  - The descriptor may change from the cycle after `req_ready`; the latched copy is used.
  - Dropping `req_valid` before grant withdraws the request without error.
- `mm_done` outside WAIT is ignored.
- Descriptor fields pass through unmodified; no arithmetic is done on them.
- `job_count` wraps 65535→0.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: `req_ready`, `rsp_*`, `mm_*`, `busy`, `grant_id`, both counters.
  - `last_grant` is set to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-job aborts the job silently: no `rsp_*` pulse. The multiplier is reset by the same `rst_n`.
- Outputs are registered.
- Grant latency: `req_valid` high at edge T in IDLE gives `req_ready`/`mm_start` high for the cycle after T.
- Response latency:
  - `mm_done` sampled at edge D gives `rsp_done` high for the cycle after D, with state IDLE in that same cycle.
  - The next grant can launch one cycle later.
- Minimum spacing between consecutive `mm_start` pulses is 3 cycles plus the multiplier latency.
- A timeout error pulse appears TIMEOUT_CYCLES+1 cycles after `mm_start`.
- `mm_*` descriptor outputs hold their values until the next grant.

## Test plan
- **Single job:** req0 = 4x8x4, bases 0/64/128, `mm_ready`=1, `mm_done` 20 cycles after start.
  - Expect `req_ready[0]` and `mm_start` in the same cycle, `mm_rows_a`=4, `mm_base_c`=128.
  - Expect `rsp_done[0]` one cycle after `mm_done`; `job_count`=1.
- **Round-robin:** all 4 requesters valid continuously, `done` returned after 5 cycles.
  - Expect grant order 0,1,2,3,0; each `req_ready` one-hot; exactly one `mm_start` per grant.
- **Zero dimension:** req2 with `cols_a`=0.
  - Expect `req_ready[2]` and `rsp_error[2]` in the same cycle, no `mm_start`, `error_count`=1, next grant goes to req3.
- **Timeout:** TIMEOUT_CYCLES=16, `mm_done` never asserted.
  - Expect `rsp_error[g]` exactly 17 cycles after `mm_start`.
  - Then, with `mm_ready`=0, no further grant until `mm_ready` rises.
- **Collision and stale done:**
  - `mm_done` on the timeout cycle: expect `rsp_done`, not `rsp_error`.
  - Stray `mm_done` in IDLE: expect no response pulse.
- **Reset mid-job:** `rst_n` low for 1 cycle during WAIT.
  - Expect all outputs 0 and no `rsp_*` pulse.
  - With req1 and req0 both valid afterwards, expect the first grant to go to req0.

Source files
------------

// File: rtl/matmul_job_scheduler.sv
// Round-robin job scheduler sharing one matrix multiplier among NUM_REQ requesters.
// Latches the winning descriptor, sequences start/done and guards each job with a watchdog.
module matmul_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DIM_WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]    req_rows_a,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]    req_cols_a,
    input  logic [NUM_REQ*DIM_WIDTH-1:0]    req_cols_b,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_a,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_b,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_base_c,
    output logic [NUM_REQ-1:0]              rsp_done,
    output logic [NUM_REQ-1:0]              rsp_error,
    output logic                            mm_start,
    output logic [DIM_WIDTH-1:0]            mm_rows_a,
    output logic [DIM_WIDTH-1:0]            mm_cols_a,
    output logic [DIM_WIDTH-1:0]            mm_cols_b,
    output logic [ADDR_WIDTH-1:0]           mm_base_a,
    output logic [ADDR_WIDTH-1:0]           mm_base_b,
    output logic [ADDR_WIDTH-1:0]           mm_base_c,
    input  logic                            mm_ready,
    input  logic                            mm_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [15:0]                     job_count,
    output logic [7:0]                      error_count
);

    localparam int unsigned IdW = $clog2(NUM_REQ);
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StReject,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         last_q, last_d;
    logic [IdW-1:0]         gnt_q, gnt_d;
    logic [DIM_WIDTH-1:0]   rows_a_q, rows_a_d;
    logic [DIM_WIDTH-1:0]   cols_a_q, cols_a_d;
    logic [DIM_WIDTH-1:0]   cols_b_q, cols_b_d;
    logic [ADDR_WIDTH-1:0]  base_a_q, base_a_d;
    logic [ADDR_WIDTH-1:0]  base_b_q, base_b_d;
    logic [ADDR_WIDTH-1:0]  base_c_q, base_c_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]     rsp_done_q, rsp_done_d;
    logic [NUM_REQ-1:0]     rsp_error_q, rsp_error_d;
    logic                   mm_start_q, mm_start_d;
    logic [WdW-1:0]         wdog_q, wdog_d;
    logic [15:0]            job_q, job_d;
    logic [7:0]             err_q, err_d;

    logic                   found;
    logic [IdW-1:0]         win;
    logic [DIM_WIDTH-1:0]   win_rows_a, win_cols_a, win_cols_b;
    logic [NUM_REQ-1:0]     win_onehot, gnt_onehot;

    // Round-robin search begins just after the last requester that finished a job.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
    end

    assign win_rows_a = req_rows_a[win*DIM_WIDTH +: DIM_WIDTH];
    assign win_cols_a = req_cols_a[win*DIM_WIDTH +: DIM_WIDTH];
    assign win_cols_b = req_cols_b[win*DIM_WIDTH +: DIM_WIDTH];
    assign win_onehot = NUM_REQ'(1) << win;
    assign gnt_onehot = NUM_REQ'(1) << gnt_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        rows_a_d    = rows_a_q;
        cols_a_d    = cols_a_q;
        cols_b_d    = cols_b_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        base_c_d    = base_c_q;
        req_ready_d = '0;
        rsp_done_d  = '0;
        rsp_error_d = '0;
        mm_start_d  = 1'b0;
        wdog_d      = wdog_q;
        job_d       = job_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (mm_ready && found) begin
                    gnt_d       = win;
                    rows_a_d    = win_rows_a;
                    cols_a_d    = win_cols_a;
                    cols_b_d    = win_cols_b;
                    base_a_d    = req_base_a[win*ADDR_WIDTH +: ADDR_WIDTH];
                    base_b_d    = req_base_b[win*ADDR_WIDTH +: ADDR_WIDTH];
                    base_c_d    = req_base_c[win*ADDR_WIDTH +: ADDR_WIDTH];
                    req_ready_d = win_onehot;
                    if (win_rows_a == '0 || win_cols_a == '0 || win_cols_b == '0) begin
                        rsp_error_d = win_onehot;
                        state_d     = StReject;
                    end else begin
                        mm_start_d = 1'b1;
                        state_d    = StLaunch;
                    end
                end
            end
            StLaunch: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StReject: begin
                if (err_q != 8'hff) err_d = err_q + 8'd1;
                last_d  = gnt_q;
                state_d = StIdle;
            end
            StWait: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (mm_done) begin
                    rsp_done_d = gnt_onehot;
                    job_d      = job_q + 16'd1;
                    last_d     = gnt_q;
                    state_d    = StIdle;
                end else if (wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_error_d = gnt_onehot;
                    if (err_q != 8'hff) err_d = err_q + 8'd1;
                    last_d      = gnt_q;
                    state_d     = StIdle;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= IdW'(NUM_REQ - 1);
            gnt_q       <= '0;
            rows_a_q    <= '0;
            cols_a_q    <= '0;
            cols_b_q    <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            req_ready_q <= '0;
            rsp_done_q  <= '0;
            rsp_error_q <= '0;
            mm_start_q  <= 1'b0;
            wdog_q      <= '0;
            job_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rows_a_q    <= rows_a_d;
            cols_a_q    <= cols_a_d;
            cols_b_q    <= cols_b_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_c_q    <= base_c_d;
            req_ready_q <= req_ready_d;
            rsp_done_q  <= rsp_done_d;
            rsp_error_q <= rsp_error_d;
            mm_start_q  <= mm_start_d;
            wdog_q      <= wdog_d;
            job_q       <= job_d;
            err_q       <= err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_done    = rsp_done_q;
    assign rsp_error   = rsp_error_q;
    assign mm_start    = mm_start_q;
    assign mm_rows_a   = rows_a_q;
    assign mm_cols_a   = cols_a_q;
    assign mm_cols_b   = cols_b_q;
    assign mm_base_a   = base_a_q;
    assign mm_base_b   = base_b_q;
    assign mm_base_c   = base_c_q;
    assign busy        = (state_q != StIdle);
    assign grant_id    = gnt_q;
    assign job_count   = job_q;
    assign error_count = err_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler: one instance at the default watchdog limit,
// a second with a 16-cycle watchdog for the timeout and collision scenarios.
module tb_matmul_job_scheduler;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_rows_a, req_cols_a, req_cols_b;
    logic [NR*AW-1:0]  req_base_a, req_base_b, req_base_c;
    logic              mm_ready, mm_done;

    logic [NR-1:0]     req_ready, rsp_done, rsp_error;
    logic              mm_start, busy;
    logic [DW-1:0]     mm_rows_a, mm_cols_a, mm_cols_b;
    logic [AW-1:0]     mm_base_a, mm_base_b, mm_base_c;
    logic [1:0]        grant_id;
    logic [15:0]       job_count;
    logic [7:0]        error_count;

    logic [NR-1:0]     t_req_ready, t_rsp_done, t_rsp_error;
    logic              t_mm_start, t_busy;
    logic [DW-1:0]     t_mm_rows_a, t_mm_cols_a, t_mm_cols_b;
    logic [AW-1:0]     t_mm_base_a, t_mm_base_b, t_mm_base_c;
    logic [1:0]        t_grant_id;
    logic [15:0]       t_job_count;
    logic [7:0]        t_error_count;

    matmul_job_scheduler #(
        .NUM_REQ(NR), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(65535)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rows_a(req_rows_a), .req_cols_a(req_cols_a), .req_cols_b(req_cols_b),
        .req_base_a(req_base_a), .req_base_b(req_base_b), .req_base_c(req_base_c),
        .rsp_done(rsp_done), .rsp_error(rsp_error), .mm_start(mm_start),
        .mm_rows_a(mm_rows_a), .mm_cols_a(mm_cols_a), .mm_cols_b(mm_cols_b),
        .mm_base_a(mm_base_a), .mm_base_b(mm_base_b), .mm_base_c(mm_base_c),
        .mm_ready(mm_ready), .mm_done(mm_done), .busy(busy), .grant_id(grant_id),
        .job_count(job_count), .error_count(error_count)
    );

    matmul_job_scheduler #(
        .NUM_REQ(NR), .DIM_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut_t (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(t_req_ready),
        .req_rows_a(req_rows_a), .req_cols_a(req_cols_a), .req_cols_b(req_cols_b),
        .req_base_a(req_base_a), .req_base_b(req_base_b), .req_base_c(req_base_c),
        .rsp_done(t_rsp_done), .rsp_error(t_rsp_error), .mm_start(t_mm_start),
        .mm_rows_a(t_mm_rows_a), .mm_cols_a(t_mm_cols_a), .mm_cols_b(t_mm_cols_b),
        .mm_base_a(t_mm_base_a), .mm_base_b(t_mm_base_b), .mm_base_c(t_mm_base_c),
        .mm_ready(mm_ready), .mm_done(mm_done), .busy(t_busy), .grant_id(t_grant_id),
        .job_count(t_job_count), .error_count(t_error_count)
    );

    int checks = 0;
    int errors = 0;
    int starts = 0;

    always @(negedge clk) if (mm_start === 1'b1) starts++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int i, input int ra, input int ca, input int cb,
                            input int ba, input int bb, input int bc);
        req_rows_a[i*DW +: DW] = DW'(ra);
        req_cols_a[i*DW +: DW] = DW'(ca);
        req_cols_b[i*DW +: DW] = DW'(cb);
        req_base_a[i*AW +: AW] = AW'(ba);
        req_base_b[i*AW +: AW] = AW'(bb);
        req_base_c[i*AW +: AW] = AW'(bc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; mm_done = 1'b0; mm_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic run_grant(input int exp);
        int n;
        n = 0;
        while (req_ready == '0 && n < 20) begin step(); n++; end
        chk("rr_wait_bound", 32'(n < 20), 32'd1);
        chk("rr_ready_onehot", 32'(req_ready), 32'(1 << exp));
        chk("rr_start", 32'(mm_start), 32'd1);
        chk("rr_grant_id", 32'(grant_id), 32'(exp));
        chk("rr_rows_a", 32'(mm_rows_a), 32'(exp + 1));
        step();
        chk("rr_ready_pulse", 32'(req_ready), 32'd0);
        step(); step(); step();
        mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("rr_done", 32'(rsp_done), 32'(1 << exp));
    endtask

    initial begin
        int k;
        int s0;
        req_rows_a = '0; req_cols_a = '0; req_cols_b = '0;
        req_base_a = '0; req_base_b = '0; req_base_c = '0;
        rst_n = 1'b0; req_valid = '0; mm_done = 1'b0; mm_ready = 1'b0;
        step(); step();
        chk("reset_outputs", {req_ready, rsp_done, rsp_error, mm_start, busy, grant_id}, 32'd0);
        chk("reset_counts", {job_count, error_count}, 32'd0);
        rst_n = 1'b1;

        // Single job on requester 0
        set_desc(0, 4, 8, 4, 0, 64, 128);
        mm_ready = 1'b1; req_valid = 4'b0001;
        step();
        chk("single_ready", 32'(req_ready), 32'b0001);
        chk("single_start", 32'(mm_start), 32'd1);
        chk("single_rows_a", 32'(mm_rows_a), 32'd4);
        chk("single_base_c", 32'(mm_base_c), 32'd128);
        req_valid = '0;
        for (int i = 0; i < 19; i++) step();
        chk("single_no_early_done", 32'(rsp_done), 32'd0);
        mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("single_done", 32'(rsp_done), 32'b0001);
        chk("single_job_count", 32'(job_count), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);

        // Round-robin with all requesters pending
        do_reset();
        for (int i = 0; i < NR; i++) set_desc(i, i + 1, 2, 3, i, 100 + i, 200 + i);
        s0 = starts;
        req_valid = 4'b1111;
        run_grant(0); run_grant(1); run_grant(2); run_grant(3); run_grant(0);
        req_valid = '0;
        step();
        chk("rr_start_count", 32'(starts - s0), 32'd5);
        chk("rr_job_count", 32'(job_count), 32'd5);

        // Zero dimension on requester 2, requester 3 also pending
        do_reset();
        set_desc(2, 4, 0, 4, 1, 2, 3);
        set_desc(3, 5, 6, 7, 8, 9, 10);
        req_valid = 4'b1100;
        step();
        chk("zero_ready", 32'(req_ready), 32'b0100);
        chk("zero_error", 32'(rsp_error), 32'b0100);
        chk("zero_no_start", 32'(mm_start), 32'd0);
        req_valid = 4'b1000;
        step();
        chk("zero_err_count", 32'(error_count), 32'd1);
        step();
        chk("zero_next_ready", 32'(req_ready), 32'b1000);
        chk("zero_next_start", 32'(mm_start), 32'd1);
        chk("zero_next_gid", 32'(grant_id), 32'd3);
        req_valid = '0;
        step(); mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("zero_next_done", 32'(rsp_done), 32'b1000);

        // Timeout on the short-watchdog instance
        do_reset();
        set_desc(1, 3, 3, 3, 4, 5, 6);
        set_desc(0, 2, 2, 2, 7, 8, 9);
        req_valid = 4'b0010;
        step();
        chk("to_start", 32'(t_mm_start), 32'd1);
        req_valid = '0; mm_ready = 1'b0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            k = i;
            if (t_rsp_error != '0) break;
        end
        chk("to_latency", 32'(k), 32'(TO + 1));
        chk("to_error", 32'(t_rsp_error), 32'b0010);
        chk("to_no_done", 32'(t_rsp_done), 32'd0);
        chk("to_err_count", 32'(t_error_count), 32'd1);
        req_valid = 4'b0001;
        step(); step(); step(); step();
        chk("to_no_grant_not_ready", 32'(t_req_ready), 32'd0);
        chk("to_idle_not_ready", 32'(t_busy), 32'd0);
        mm_ready = 1'b1;
        step();
        chk("to_grant_on_ready", 32'(t_req_ready), 32'b0001);
        req_valid = '0;

        // Done collides with the timeout cycle
        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int i = 0; i < TO; i++) step();
        mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("coll_done", 32'(t_rsp_done), 32'b0001);
        chk("coll_no_error", 32'(t_rsp_error), 32'd0);
        chk("coll_counts", {t_job_count, t_error_count}, {16'd1, 8'd0});

        // Stray done in IDLE
        step();
        mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("stray_t_rsp", {t_rsp_done, t_rsp_error}, 32'd0);
        step();
        chk("stray_t_rsp_late", {t_rsp_done, t_rsp_error}, 32'd0);
        chk("stray_t_job_count", 32'(t_job_count), 32'd1);

        // Reset in the middle of a job
        do_reset();
        req_valid = 4'b0001;
        step(); req_valid = '0;
        step(); mm_done = 1'b1; step(); mm_done = 1'b0;
        chk("mid_first_done", 32'(rsp_done), 32'b0001);
        req_valid = 4'b0001;
        step(); req_valid = '0;
        chk("mid_second_start", 32'(mm_start), 32'd1);
        step(); step(); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mid_reset_ctrl", {req_ready, rsp_done, rsp_error, mm_start, busy, grant_id}, 32'd0);
        chk("mid_reset_dims", {mm_rows_a, mm_cols_a}, 32'd0);
        chk("mid_reset_base", {mm_cols_b, mm_base_a}, 32'd0);
        chk("mid_reset_base_bc", {mm_base_b, mm_base_c}, 32'd0);
        chk("mid_reset_counts", {job_count, error_count}, 32'd0);
        req_valid = 4'b0011;
        step();
        chk("mid_after_rsp", {rsp_done, rsp_error}, 32'd0);
        chk("mid_first_grant", 32'(req_ready), 32'b0001);
        chk("mid_first_gid", 32'(grant_id), 32'd0);
        req_valid = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
